bus_grant_seq: RTL and testbench



---
 rtl/bus_grant_seq_pkg.sv | 23 ++
 rtl/bus_grant_seq_prienc.sv | 28 ++
 rtl/bus_grant_seq.sv | 101 ++++++++++
 tb/tb_bus_grant_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_grant_seq_pkg.sv
// Shared definitions for the KS10 backplane bus grant sequencer:
// master index constants, FSM state encodings and the default timeout.
package bus_grant_seq_pkg;

  // Grant vector positions / master indices, highest priority first
  localparam int GNT_CSL  = 0;
  localparam int GNT_UBA0 = 1;
  localparam int GNT_UBA1 = 2;
  localparam int GNT_UBA2 = 3;
  localparam int GNT_UBA3 = 4;
  localparam int GNT_CPU  = 5;
  localparam int NMST     = 6;

  // Default number of cycles a grant may wait for busACKI
  localparam int TMOCNT_DEF = 127;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/bus_grant_seq_prienc.sv
// Combinational fixed-priority encoder over the six bus masters.
// Index 0 (console) wins over everything, index 5 (CPU) loses to all.
module bus_grant_seq_prienc
  import bus_grant_seq_pkg::*;
(
  input  logic [0:NMST-1] reqVec,
  output logic [0:NMST-1] oneHot,
  output logic [2:0]      idx,
  output logic            anyReq
);

  // Scan from lowest to highest priority so the last hit is the winner
  always_comb begin
    oneHot = '0;
    idx    = '0;
    anyReq = 1'b0;
    for (int i = NMST - 1; i >= 0; i--) begin
      if (reqVec[i]) begin
        idx    = 3'(i);
        anyReq = 1'b1;
      end
    end
    if (anyReq) begin
      oneHot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_grant_seq.sv
// Registered bus grant sequencer for the KS10 backplane.
// Handshake: a master holds its REQ high until it sees its grant and then
// until busACKI (or tmoO, the substitute ack) arrives; dropping REQ while
// granted is an abort. A grant is held from acceptance until ack, abort or
// watchdog expiry, followed by one dead turnaround cycle.
module bus_grant_seq
  import bus_grant_seq_pkg::*;
#(
  parameter int TMOCNT = TMOCNT_DEF,
  parameter int TW     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cslREQI,
  input  logic [0:3]  ubaREQI,
  input  logic        cpuREQI,
  input  logic        busACKI,
  input  logic [0:35] arbADDRI,
  output logic [0:5]  grantO,
  output logic        busyO,
  output logic        tmoO,
  output logic [0:35] nxmADDRO,
  output logic [0:2]  nxmDEVO,
  output logic [1:0]  dbgStateO
);

  state_t          state;
  logic [TW-1:0]   timer;
  logic [2:0]      gntIdx;
  logic [0:NMST-1] reqVec;
  logic [0:NMST-1] pickOneHot;
  logic [2:0]      pickIdx;
  logic            anyReq;
  logic            reqHeld;
  logic            timeout;

  assign reqVec    = {cslREQI, ubaREQI, cpuREQI};
  assign reqHeld   = reqVec[gntIdx];
  assign timeout   = (timer == TW'(TMOCNT - 1));
  assign dbgStateO = state;

  bus_grant_seq_prienc u_prienc (
    .reqVec (reqVec),
    .oneHot (pickOneHot),
    .idx    (pickIdx),
    .anyReq (anyReq)
  );

  // Grant FSM with watchdog timer and non-existent device capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grantO   <= '0;
      busyO    <= 1'b0;
      tmoO     <= 1'b0;
      nxmADDRO <= '0;
      nxmDEVO  <= '0;
      timer    <= '0;
      gntIdx   <= '0;
    end else begin
      tmoO <= 1'b0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            grantO <= pickOneHot;
            gntIdx <= pickIdx;
            busyO  <= 1'b1;
            timer  <= '0;
            state  <= GRANT;
          end
        end
        GRANT: begin
          // Saturate rather than wrap so a stuck grant cannot re-arm
          if (timer != {TW{1'b1}}) begin
            timer <= timer + 1'b1;
          end
          if (busACKI || !reqHeld || timeout) begin
            grantO <= '0;
            busyO  <= 1'b0;
            state  <= DONE;
          end
          // Ack and abort both take precedence over the watchdog
          if (!busACKI && reqHeld && timeout) begin
            tmoO     <= 1'b1;
            nxmADDRO <= arbADDRI;
            nxmDEVO  <= gntIdx;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          grantO <= '0;
          busyO  <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_grant_seq.sv
// Directed bench for bus_grant_seq with a short watchdog (TMOCNT=8).
module tb_bus_grant_seq;

  logic        clk;
  logic        rst;
  logic        cslREQI;
  logic [0:3]  ubaREQI;
  logic        cpuREQI;
  logic        busACKI;
  logic [0:35] arbADDRI;
  logic [0:5]  grantO;
  logic        busyO;
  logic        tmoO;
  logic [0:35] nxmADDRO;
  logic [0:2]  nxmDEVO;
  logic [1:0]  dbgStateO;

  int vecCnt = 0;
  int errCnt = 0;
  logic [5:0] exp_q[$];

  bus_grant_seq #(.TMOCNT(8), .TW(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .cslREQI   (cslREQI),
    .ubaREQI   (ubaREQI),
    .cpuREQI   (cpuREQI),
    .busACKI   (busACKI),
    .arbADDRI  (arbADDRI),
    .grantO    (grantO),
    .busyO     (busyO),
    .tmoO      (tmoO),
    .nxmADDRO  (nxmADDRO),
    .nxmDEVO   (nxmDEVO),
    .dbgStateO (dbgStateO)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkVal(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vecCnt++;
    if (act !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Compare the current grant against the next entry of the expected queue
  task automatic chkGrant(input string tag);
    logic [5:0] e;
    if (exp_q.size() == 0) begin
      chkVal({tag, "_qempty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chkVal(tag, 64'(grantO), 64'(e));
    end
  endtask

  initial begin
    int k;
    rst      = 1'b1;
    cslREQI  = 1'b0;
    ubaREQI  = '0;
    cpuREQI  = 1'b0;
    busACKI  = 1'b0;
    arbADDRI = '0;
    tick();
    tick();

    // Reset state
    chkVal("rst_grant", 64'(grantO), 64'd0);
    chkVal("rst_busy",  64'(busyO), 64'd0);
    chkVal("rst_tmo",   64'(tmoO), 64'd0);
    chkVal("rst_nxmA",  64'(nxmADDRO), 64'd0);
    chkVal("rst_nxmD",  64'(nxmDEVO), 64'd0);
    chkVal("rst_state", 64'(dbgStateO), 64'd0);
    rst = 1'b0;
    tick();
    chkVal("idle_noreq", 64'(grantO), 64'd0);

    // Priority: console, UBA2 and CPU together
    exp_q.push_back(6'b100000);
    exp_q.push_back(6'b000100);
    exp_q.push_back(6'b000001);
    cslREQI    = 1'b1;
    ubaREQI[2] = 1'b1;
    cpuREQI    = 1'b1;
    tick();
    chkGrant("pri_csl");
    chkVal("pri_busy", 64'(busyO), 64'd1);
    busACKI = 1'b1;
    cslREQI = 1'b0;
    tick();
    chkVal("pri_done_gnt",  64'(grantO), 64'd0);
    chkVal("pri_done_busy", 64'(busyO), 64'd0);
    chkVal("pri_done_st",   64'(dbgStateO), 64'd2);
    busACKI = 1'b0;
    tick();
    chkVal("pri_idle_gnt", 64'(grantO), 64'd0);
    tick();
    chkGrant("pri_uba2");
    busACKI    = 1'b1;
    ubaREQI[2] = 1'b0;
    tick();
    chkVal("pri_done2", 64'(grantO), 64'd0);
    busACKI = 1'b0;
    tick();
    tick();
    chkGrant("pri_cpu");

    // No preemption: console arrives while CPU holds the bus
    cslREQI = 1'b1;
    tick();
    chkVal("nopre_1", 64'(grantO), 64'b000001);
    tick();
    chkVal("nopre_2", 64'(grantO), 64'b000001);
    busACKI = 1'b1;
    tick();
    chkVal("nopre_done", 64'(grantO), 64'd0);
    busACKI = 1'b0;
    cpuREQI = 1'b0;
    tick();
    chkVal("nopre_idle", 64'(grantO), 64'd0);
    tick();
    chkVal("nopre_csl", 64'(grantO), 64'b100000);
    busACKI = 1'b1;
    cslREQI = 1'b0;
    tick();
    busACKI = 1'b0;
    tick();
    tick();

    // Timeout: UBA2 with no ack
    arbADDRI   = 36'o000000001234;
    ubaREQI[2] = 1'b1;
    tick();
    chkVal("tmo_gnt", 64'(grantO), 64'b000100);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (tmoO) begin
        k = i;
        break;
      end
    end
    chkVal("tmo_latency", 64'(k), 64'd8);
    chkVal("tmo_pulse",   64'(tmoO), 64'd1);
    chkVal("tmo_gntrel",  64'(grantO), 64'd0);
    chkVal("tmo_busy",    64'(busyO), 64'd0);
    chkVal("tmo_nxmA",    64'(nxmADDRO), 64'o000000001234);
    chkVal("tmo_nxmD",    64'(nxmDEVO), 64'd3);
    ubaREQI[2] = 1'b0;
    tick();
    chkVal("tmo_1cyc", 64'(tmoO), 64'd0);
    tick();

    // Ack / timeout race on UBA0: ack wins
    arbADDRI   = 36'o000000007777;
    ubaREQI[0] = 1'b1;
    tick();
    chkVal("race_gnt", 64'(grantO), 64'b010000);
    for (int i = 0; i < 7; i++) tick();
    chkVal("race_pre_tmo", 64'(tmoO), 64'd0);
    busACKI = 1'b1;
    tick();
    chkVal("race_tmo",  64'(tmoO), 64'd0);
    chkVal("race_gnt0", 64'(grantO), 64'd0);
    chkVal("race_nxmA", 64'(nxmADDRO), 64'o000000001234);
    chkVal("race_nxmD", 64'(nxmDEVO), 64'd3);
    busACKI    = 1'b0;
    ubaREQI[0] = 1'b0;
    tick();
    chkVal("race_tmo2", 64'(tmoO), 64'd0);
    tick();

    // Abort: CPU drops its request after two granted cycles
    cpuREQI = 1'b1;
    tick();
    chkVal("abt_gnt", 64'(grantO), 64'b000001);
    tick();
    tick();
    cpuREQI = 1'b0;
    tick();
    chkVal("abt_done",  64'(grantO), 64'd0);
    chkVal("abt_st",    64'(dbgStateO), 64'd2);
    chkVal("abt_tmo",   64'(tmoO), 64'd0);
    tick();
    chkVal("abt_idle",  64'(dbgStateO), 64'd0);
    chkVal("abt_tmo2",  64'(tmoO), 64'd0);

    // Asynchronous reset in the middle of a grant
    cpuREQI = 1'b1;
    tick();
    chkVal("arst_gnt", 64'(grantO), 64'b000001);
    #2;
    rst = 1'b1;
    #1;
    chkVal("arst_gnt0", 64'(grantO), 64'd0);
    chkVal("arst_busy", 64'(busyO), 64'd0);
    chkVal("arst_tmo",  64'(tmoO), 64'd0);
    cpuREQI = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    chkVal("arst_idle", 64'(dbgStateO), 64'd0);
    chkVal("arst_gntz", 64'(grantO), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
